memory_unit: RTL

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/memory_unit.sv
// Single-port word memory with IDLE/ACCESS/DONE handshake; reads land in a registered mem2mbr.
// Optional macro MEM_WAIT_STATES_EN stretches ACCESS to WAIT_CYCLES cycles (otherwise 1).
module memory_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       control_signals,
    input  logic [ADDR_W-1:0] mar2mem,
    input  logic [DATA_W-1:0] mbr2mem,
    output logic [DATA_W-1:0] mem2mbr,
    output logic              mem_busy,
    output logic              mem_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;
    logic              access_end;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    wire rd_req = control_signals[10];
    wire wr_req = control_signals[11];
    wire unused_ctrl = ^{control_signals[15:12], control_signals[9:0]};

    assign accept = (state_q == IDLE) && (rd_req || wr_req);

`ifdef MEM_WAIT_STATES_EN
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 4'(WAIT_CYCLES);
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the cycles still to spend in ACCESS, including the current one.
    assign access_end = (state_q == ACCESS) && (cnt_q == 4'd1);
`else
    wire [3:0] unused_wait = 4'(WAIT_CYCLES);

    assign access_end = (state_q == ACCESS);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = mar2mem;
                    data_d  = mbr2mem;
                    // A simultaneous read+write request is treated as a write only.
                    wr_d    = wr_req;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (access_end) begin
                    if (!wr_q) begin
                        rdata_d = mem_q[addr_q];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; an async reset returns the FSM to IDLE so a pending write never commits.
    always_ff @(posedge clk) begin
        if (access_end && wr_q) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign mem2mbr  = rdata_q;
    assign mem_busy = (state_q == ACCESS) || (state_q == DONE);
    assign mem_done = (state_q == DONE);

endmodule
